// File: rtl/axis_upsizer_pkg.sv
// Shared definitions for the RX-path 8-to-64 AXI-Stream upsizer.
package axis_upsizer_pkg;

    localparam int M_DATA_WIDTH = 64;
    localparam int M_KEEP_WIDTH = M_DATA_WIDTH / 8;
    localparam int IDX_WIDTH    = $clog2(M_KEEP_WIDTH);

    typedef enum logic [1:0] {
        PACK        = 2'd0,
        DROP_TERM   = 2'd1,
        TERM        = 2'd2,
        DROP_SILENT = 2'd3
    } state_e;

    // Terminator word closing a frame that lost data: one zero byte flagged bad.
    localparam logic [M_DATA_WIDTH-1:0] TERM_TDATA = '0;
    localparam logic [M_KEEP_WIDTH-1:0] TERM_TKEEP = M_KEEP_WIDTH'(1);
    localparam logic                    TERM_TLAST = 1'b1;
    localparam logic                    TERM_TUSER = 1'b1;

endpackage

// File: rtl/axis_gmii_rx_upsizer.sv
// Packs the stall-free GMII RX byte stream into 64-bit AXI-Stream words; frames
// that hit a full holding register are closed with a bad terminator word.
module axis_gmii_rx_upsizer #(
    parameter int S_DATA_WIDTH = 8,
    parameter int M_DATA_WIDTH = 64,
    parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic                    overflow,
    output logic                    frame_drop,
    output logic [1:0]              dbg_state
);
    import axis_upsizer_pkg::*;

    localparam int IDX_W = (M_KEEP_WIDTH > 1) ? $clog2(M_KEEP_WIDTH) : 1;

    // Handshake: a word transfers on any edge where m_axis_tvalid && m_axis_tready;
    // once raised, m_axis_tvalid and the word stay unchanged until that edge.

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [M_DATA_WIDTH-1:0] acc_q, acc_d;
    logic                    pend_q, pend_d;

    logic [M_DATA_WIDTH-1:0] hdata_q, hdata_d;
    logic [M_KEEP_WIDTH-1:0] hkeep_q, hkeep_d;
    logic                    hlast_q, hlast_d;
    logic                    huser_q, huser_d;
    logic                    hvalid_q, hvalid_d;

    logic                    ovf_q, ovf_d;
    logic                    drop_q, drop_d;

    logic                    drain;
    logic                    hold_free;
    logic                    last_lane;
    logic                    silent;
    logic [M_DATA_WIDTH-1:0] packed_word;
    logic [M_KEEP_WIDTH-1:0] lane_mask;

    assign drain     = hvalid_q && m_axis_tready;
    assign hold_free = !hvalid_q || drain;
    assign last_lane = (idx_q == IDX_W'(M_KEEP_WIDTH - 1));

    // Lanes above idx are already zero because the accumulator clears on completion.
    always_comb begin
        packed_word = acc_q;
        lane_mask   = '0;
        for (int i = 0; i < M_KEEP_WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) begin
                packed_word[i*8 +: 8] = s_axis_tdata[7:0];
            end
            lane_mask[i] = (IDX_W'(i) <= idx_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        pend_d   = pend_q;
        hdata_d  = hdata_q;
        hkeep_d  = hkeep_q;
        hlast_d  = hlast_q;
        huser_d  = huser_q;
        hvalid_d = drain ? 1'b0 : hvalid_q;
        ovf_d    = 1'b0;
        drop_d   = 1'b0;
        silent   = pend_q;

        case (state_q)
            PACK: begin
                if (s_axis_tvalid) begin
                    if (last_lane || s_axis_tlast) begin
                        idx_d = '0;
                        acc_d = '0;
                        if (hold_free) begin
                            hdata_d  = packed_word;
                            hkeep_d  = lane_mask;
                            hlast_d  = s_axis_tlast;
                            huser_d  = s_axis_tuser & s_axis_tlast;
                            hvalid_d = 1'b1;
                        end else begin
                            ovf_d   = 1'b1;
                            state_d = s_axis_tlast ? TERM : DROP_TERM;
                        end
                    end else begin
                        acc_d = packed_word;
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            DROP_TERM: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = TERM;
                end
            end

            TERM: begin
                // A frame starting while the terminator waits is lost whole.
                if (s_axis_tvalid) begin
                    drop_d = 1'b1;
                    if (!s_axis_tlast) begin
                        pend_d = 1'b1;
                        silent = 1'b1;
                    end
                end
                if (hold_free) begin
                    hdata_d  = TERM_TDATA[M_DATA_WIDTH-1:0];
                    hkeep_d  = TERM_TKEEP[M_KEEP_WIDTH-1:0];
                    hlast_d  = TERM_TLAST;
                    huser_d  = TERM_TUSER;
                    hvalid_d = 1'b1;
                    pend_d   = 1'b0;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = silent ? DROP_SILENT : PACK;
                end
            end

            DROP_SILENT: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = PACK;
                end
            end

            default: state_d = PACK;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= PACK;
            idx_q    <= '0;
            acc_q    <= '0;
            pend_q   <= 1'b0;
            hdata_q  <= '0;
            hkeep_q  <= '0;
            hlast_q  <= 1'b0;
            huser_q  <= 1'b0;
            hvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            pend_q   <= pend_d;
            hdata_q  <= hdata_d;
            hkeep_q  <= hkeep_d;
            hlast_q  <= hlast_d;
            huser_q  <= huser_d;
            hvalid_q <= hvalid_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    assign m_axis_tdata  = hdata_q;
    assign m_axis_tkeep  = hkeep_q;
    assign m_axis_tvalid = hvalid_q;
    assign m_axis_tlast  = hlast_q;
    assign m_axis_tuser  = huser_q;
    assign overflow      = ovf_q;
    assign frame_drop    = drop_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_axis_gmii_rx_upsizer.sv
// Self-checking bench for axis_gmii_rx_upsizer: frame table, hand-built corner
// sequences, and randomized traffic against a frame-chunking reference model.
module tb_axis_gmii_rx_upsizer;

    localparam int W  = 74;
    localparam int CW = 80;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        overflow;
    logic        frame_drop;
    logic [1:0]  dbg_state;

    always #5 aclk = ~aclk;

    axis_gmii_rx_upsizer dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .overflow      (overflow),
        .frame_drop    (frame_drop),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];
    logic [7:0]   fr[$];
    int ovf_cnt = 0;
    int drop_cnt = 0;
    int rdy_mode = 0;
    logic rdy_manual = 1'b1;
    int rdy_low_run = 0;

    typedef struct {
        int         len;
        logic       user;
        int         nwords;
        logic [7:0] last_keep;
    } vec_t;
    vec_t tbl[7];

    function automatic logic [W-1:0] mk(input logic [63:0] d, input logic [7:0] k,
                                        input logic l, input logic u);
        return {u, l, k, d};
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: collects accepted words, counts pulses, checks stability under stall.
    logic         stall_prev = 1'b0;
    logic [W:0]   prev_word = '0;
    always @(negedge aclk) begin
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_stable",
                      {m_axis_tvalid, mk(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser)},
                      prev_word);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                rx_q.push_back(mk(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser));
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tvalid, mk(m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser)};
            if (overflow) ovf_cnt++;
            if (frame_drop) drop_cnt++;
        end
    end

    // One clock of source activity; ready policy applied in the same step.
    task automatic tick(input logic v, input logic [7:0] d, input logic l, input logic u);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        case (rdy_mode)
            0: m_axis_tready = rdy_manual;
            1: m_axis_tready = ~m_axis_tready;
            default: begin
                if (rdy_low_run >= 3) m_axis_tready = 1'b1;
                else m_axis_tready = ($urandom_range(0, 3) != 0);
                rdy_low_run = m_axis_tready ? 0 : rdy_low_run + 1;
            end
        endcase
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    endtask

    // Reference: a frame is cut into 8-byte chunks, first byte in the low lane.
    task automatic model_frame(input logic user);
        int nw;
        nw = (fr.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            logic [63:0] d;
            logic [7:0]  k;
            d = '0;
            k = '0;
            for (int b = 0; b < 8; b++) begin
                if (w * 8 + b < fr.size()) begin
                    d[b*8 +: 8] = fr[w*8 + b];
                    k[b] = 1'b1;
                end
            end
            exp_q.push_back(mk(d, k, w == nw - 1, (w == nw - 1) && user));
        end
    endtask

    task automatic send_frame(input logic user, input bit gaps, input bit model);
        if (model) model_frame(user);
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 7) == 0) tick(1'b0, 8'h00, 1'b0, 1'b0);
            end
            tick(1'b1, fr[i], i == fr.size() - 1,
                 (i == fr.size() - 1) ? user : 1'($urandom_range(0, 1)));
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic compare_all(input string name);
        int n;
        check($sformatf("%s_count", name), rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", name, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic fill_inc(input int len, input logic [7:0] base);
        fr.delete();
        for (int i = 0; i < len; i++) fr.push_back(8'(base + 8'(i)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ovf0, drop0;
        tbl[0] = '{64, 1'b0, 8, 8'hFF};
        tbl[1] = '{61, 1'b1, 8, 8'h1F};
        tbl[2] = '{1,  1'b0, 1, 8'h01};
        tbl[3] = '{1,  1'b1, 1, 8'h01};
        tbl[4] = '{8,  1'b0, 1, 8'hFF};
        tbl[5] = '{9,  1'b1, 2, 8'h01};
        tbl[6] = '{23, 1'b0, 3, 8'h7F};

        // Reset state
        idle(3);
        @(negedge aclk);
        check("reset_outputs",
              {m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tuser, overflow, frame_drop, m_axis_tdata},
              '0);
        @(posedge aclk);
        #1 aresetn = 1'b1;
        idle(2);

        // Frame table with tready held high
        rdy_mode = 0;
        rdy_manual = 1'b1;
        for (int k = 0; k < 7; k++) begin
            fill_inc(tbl[k].len, 8'h00);
            send_frame(tbl[k].user, 1'b0, 1'b1);
            idle(4);
            check($sformatf("tbl%0d_nwords", k), rx_q.size(), tbl[k].nwords);
            if (rx_q.size() > 0) begin
                check($sformatf("tbl%0d_last_fields", k), rx_q[rx_q.size()-1][73:64],
                      {tbl[k].user, 1'b1, tbl[k].last_keep});
                if (k == 0) check("tbl0_word0_data", rx_q[0][63:0], 64'h0706050403020100);
            end
            compare_all($sformatf("tbl%0d", k));
        end

        // Overflow: 9-byte frame then 1-byte frame, tready low for 20 cycles
        ovf0 = ovf_cnt;
        drop0 = drop_cnt;
        rdy_manual = 1'b0;
        fill_inc(9, 8'h00);
        send_frame(1'b0, 1'b0, 1'b0);
        fr.delete();
        fr.push_back(8'hAA);
        send_frame(1'b0, 1'b0, 1'b0);
        idle(10);
        rdy_manual = 1'b1;
        idle(6);
        exp_q.push_back(mk(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
        exp_q.push_back(mk(64'h0, 8'h01, 1'b1, 1'b1));
        compare_all("ovf");
        check("ovf_pulses", ovf_cnt - ovf0, 1);
        check("ovf_frame_drop", drop_cnt - drop0, 1);
        fill_inc(3, 8'h41);
        send_frame(1'b0, 1'b0, 1'b1);
        idle(4);
        compare_all("after_ovf");

        // tready toggling during a 128-byte frame
        ovf0 = ovf_cnt;
        rdy_mode = 1;
        fill_inc(128, 8'h80);
        send_frame(1'b0, 1'b0, 1'b1);
        rdy_mode = 0;
        rdy_manual = 1'b1;
        idle(6);
        compare_all("toggle");
        check("toggle_no_ovf", ovf_cnt - ovf0, 0);

        // Completion on the same edge as a holding-register drain
        ovf0 = ovf_cnt;
        rdy_manual = 1'b0;
        fill_inc(16, 8'h10);
        model_frame(1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) rdy_manual = 1'b1;
            tick(1'b1, fr[i], i == 15, 1'b0);
            if (i == 7) begin
                @(negedge aclk);
                check("latency_valid", {m_axis_tvalid, m_axis_tdata}, {1'b1, exp_q[0][63:0]});
            end
        end
        @(negedge aclk);
        check("drain_load_word", {m_axis_tvalid, m_axis_tdata}, {1'b1, exp_q[1][63:0]});
        check("drain_load_drained", rx_q.size(), 1);
        idle(4);
        compare_all("drain_load");
        check("drain_load_no_ovf", ovf_cnt - ovf0, 0);

        // Reset mid-frame with a word held, release with tvalid low
        rdy_manual = 1'b0;
        fill_inc(13, 8'h20);
        send_frame(1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        aresetn = 1'b0;
        tick(1'b1, 8'h56, 1'b0, 1'b0);
        @(negedge aclk);
        check("midreset_outputs",
              {m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tuser, overflow, frame_drop, m_axis_tdata},
              '0);
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        aresetn = 1'b1;
        rdy_manual = 1'b1;
        rx_q.delete();
        idle(2);
        fill_inc(16, 8'hC0);
        send_frame(1'b0, 1'b0, 1'b1);
        idle(4);
        check("post_reset_nwords", rx_q.size(), 2);
        if (rx_q.size() == 2) check("post_reset_keeps", {rx_q[0][71:64], rx_q[1][71:64]}, 16'hFFFF);
        compare_all("post_reset");

        // Randomized traffic with compliant gaps and bounded tready stalls
        ovf0 = ovf_cnt;
        drop0 = drop_cnt;
        rdy_mode = 2;
        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 120);
            fr.delete();
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
            send_frame(1'($urandom_range(0, 1)), 1'b1, 1'b1);
            idle($urandom_range(12, 20));
        end
        rdy_mode = 0;
        rdy_manual = 1'b1;
        idle(10);
        compare_all("random");
        check("random_no_ovf", ovf_cnt - ovf0, 0);
        check("random_no_drop", drop_cnt - drop0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
